// File: rtl/sap1_prog_loader.sv
// rtl/sap1_prog_loader.sv - SAP-1 programming-mode sequencer feeding the MAR/RAM programming path
module sap1_prog_loader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int WE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              prog_we,
    output logic              select,
    output logic              cpu_clr,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [DATA_W-1:0]  data_n;
    logic               we_n, ready_n, select_n, cpu_clr_n, busy_n, done_n;
    logic               accept, pulse_end;

    // A byte is taken only while the registered ready is up in LOAD, so no input reaches an output combinationally
    assign accept    = (state == S_LOAD) && in_valid && in_ready;
    assign pulse_end = (state == S_WRITE) && (cnt == CNT_LAST);

    // State register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = S_LOAD;
            S_LOAD:  if (accept) state_n = S_WRITE;
            S_WRITE: if (pulse_end) state_n = (prog_addr == ADDR_LAST) ? S_DONE : S_LOAD;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; address/data only move outside a write pulse
    always_comb begin
        addr_n    = prog_addr;
        data_n    = prog_data;
        cnt_n     = cnt;
        we_n      = 1'b0;
        ready_n   = 1'b0;
        select_n  = select;
        cpu_clr_n = cpu_clr;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_n    = '0;
                    select_n  = 1'b0;
                    cpu_clr_n = 1'b1;
                    ready_n   = 1'b1;
                end
            end
            S_LOAD: begin
                ready_n = 1'b1;
                if (accept) begin
                    data_n  = in_data;
                    ready_n = 1'b0;
                    we_n    = 1'b1;
                    cnt_n   = '0;
                end
            end
            S_WRITE: begin
                if (pulse_end) begin
                    if (prog_addr == ADDR_LAST) begin
                        done_n = 1'b1;
                    end else begin
                        addr_n  = prog_addr + ADDR_W'(1);
                        ready_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                    we_n  = 1'b1;
                end
            end
            S_DONE: begin
                select_n  = 1'b1;
                cpu_clr_n = 1'b0;
                addr_n    = '0;
            end
            default: ;
        endcase
        busy_n = (state_n != S_IDLE);
    end

    // Output registers; clr drops the write enable at once without finishing the pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_we   <= 1'b0;
            in_ready  <= 1'b0;
            select    <= 1'b1;
            cpu_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
        end else begin
            prog_addr <= addr_n;
            prog_data <= data_n;
            prog_we   <= we_n;
            in_ready  <= ready_n;
            select    <= select_n;
            cpu_clr   <= cpu_clr_n;
            busy      <= busy_n;
            done      <= done_n;
            cnt       <= cnt_n;
        end
    end

endmodule

// File: tb/tb_sap1_prog_loader.sv
// tb/tb_sap1_prog_loader.sv - directed bench for sap1_prog_loader (16x1 and 4x3 configurations)
module tb_sap1_prog_loader;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    // 16-word, 1-clock-pulse instance
    logic       start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, prog_we, select, cpu_clr, busy, done;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    // 4-word, 3-clock-pulse instance
    logic       start5 = 1'b0, valid5 = 1'b0;
    logic [7:0] data5 = 8'h00;
    logic       ready5, we5, select5, cpu_clr5, busy5, done5;
    logic [1:0] addr5;
    logic [7:0] data5o;

    always #5 clk = ~clk;

    sap1_prog_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WE_CYCLES(1)) dut (
        .clk(clk), .clr(clr), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .prog_addr(prog_addr), .prog_data(prog_data), .prog_we(prog_we),
        .select(select), .cpu_clr(cpu_clr), .busy(busy), .done(done)
    );

    sap1_prog_loader #(.ADDR_W(2), .DATA_W(8), .DEPTH(4), .WE_CYCLES(3)) dut5 (
        .clk(clk), .clr(clr), .start(start5), .in_valid(valid5), .in_data(data5),
        .in_ready(ready5), .prog_addr(addr5), .prog_data(data5o), .prog_we(we5),
        .select(select5), .cpu_clr(cpu_clr5), .busy(busy5), .done(done5)
    );

    int n_chk = 0, n_pass = 0;

    // models of the RAMs behind each instance
    logic [7:0] ram_a [16];
    int         wcnt_a [16];
    int         nwe_a, viol_a, ndone_a, done_at_a, edges_a, first_addr_a;
    int         idx_a, gap_a;
    logic [7:0] base_a;
    bit         rnd_a;

    logic [7:0] tb5 [4];
    logic [7:0] ram_b [4];
    logic [1:0] h_addr;
    logic [7:0] h_data;
    int         run_b, badlen_b, unst_b, npulse_b, viol_b, ndone_b, done_at_b, edges_b, idx_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // one clock: record what the RAMs see at the edge, then advance the stream drivers
    task automatic cycle();
        logic acc_a, acc_b;
        acc_a = in_valid && in_ready;
        acc_b = valid5 && ready5;
        if (prog_we) begin
            ram_a[prog_addr] = prog_data;
            wcnt_a[prog_addr]++;
            if (first_addr_a < 0) first_addr_a = int'(prog_addr);
            nwe_a++;
            if (in_ready) viol_a++;
        end
        if (we5) begin
            if (run_b == 0) begin
                h_addr = addr5;
                h_data = data5o;
            end else if (addr5 !== h_addr || data5o !== h_data) begin
                unst_b++;
            end
            run_b++;
            if (ready5) viol_b++;
        end else if (run_b != 0) begin
            if (run_b != 3) badlen_b++;
            ram_b[h_addr] = h_data;
            npulse_b++;
            run_b = 0;
        end
        @(posedge clk);
        #1;
        edges_a++;
        edges_b++;
        if (done) begin
            ndone_a++;
            if (done_at_a < 0) done_at_a = edges_a;
        end
        if (done5) begin
            ndone_b++;
            if (done_at_b < 0) done_at_b = edges_b;
        end
        if (acc_a) begin
            idx_a++;
            in_data = 8'(int'(base_a) + idx_a);
            gap_a = rnd_a ? int'($urandom_range(0, 5)) : 0;
            in_valid = (gap_a == 0);
        end else if (gap_a > 0) begin
            gap_a--;
            in_valid = (gap_a == 0);
        end
        if (acc_b) begin
            idx_b++;
            data5 = tb5[idx_b % 4];
        end
    endtask

    // begins a load on the 16-word instance with bytes base, base+1, ...; the START edge is edge 1
    task automatic start_a(input logic [7:0] base, input bit rnd);
        for (int i = 0; i < 16; i++) wcnt_a[i] = 0;
        nwe_a = 0; viol_a = 0; ndone_a = 0; done_at_a = -1; edges_a = 0; first_addr_a = -1;
        base_a = base; idx_a = 0; gap_a = 0; rnd_a = rnd;
        in_data = base; in_valid = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag, input int lim);
        int n = 0;
        while (busy && n < lim) begin
            cycle();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_image_a(input string tag, input logic [7:0] base);
        int bad = 0, dup = 0;
        for (int i = 0; i < 16; i++) begin
            if (ram_a[i] !== 8'(int'(base) + i)) bad++;
            if (wcnt_a[i] != 1) dup++;
        end
        chk({tag, "_image"}, bad, 0);
        chk({tag, "_dup_or_skip"}, dup, 0);
        chk({tag, "_we_count"}, nwe_a, 16);
        chk({tag, "_ready_during_we"}, viol_a, 0);
        chk({tag, "_done_pulses"}, ndone_a, 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"}, {31'd0, prog_we}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_addr"}, {28'd0, prog_addr}, 32'd0);
        chk({tag, "_data"}, {24'd0, prog_data}, 32'd0);
        chk({tag, "_select"}, {31'd0, select}, 32'd1);
        chk({tag, "_cpu_clr"}, {31'd0, cpu_clr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        tb5[0] = 8'hA5; tb5[1] = 8'h5A; tb5[2] = 8'hFF; tb5[3] = 8'h00;
        for (int i = 0; i < 16; i++) ram_a[i] = 8'h00;
        for (int i = 0; i < 4; i++) ram_b[i] = 8'h00;
        run_b = 0; badlen_b = 0; unst_b = 0; npulse_b = 0; viol_b = 0; ndone_b = 0;
        done_at_b = -1; edges_b = 0; idx_b = 0;
        nwe_a = 0; viol_a = 0; ndone_a = 0; done_at_a = -1; edges_a = 0; first_addr_a = -1;
        idx_a = 0; gap_a = 0; base_a = 8'h00; rnd_a = 1'b0;

        // reset state while clr is held
        #12;
        check_reset("rst");
        chk("rst5_select", {31'd0, select5}, 32'd1);
        @(negedge clk) clr = 1'b0;
        @(posedge clk);
        #1;

        // T2: full load, valid held high together with START
        start_a(8'h10, 1'b0);
        chk("t2_no_we_on_start", {31'd0, prog_we}, 32'd0);
        chk("t2_ready_in_load", {31'd0, in_ready}, 32'd1);
        chk("t2_select_low", {31'd0, select}, 32'd0);
        chk("t2_cpu_clr_high", {31'd0, cpu_clr}, 32'd1);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        cycle();
        chk("t2_first_we", {31'd0, prog_we}, 32'd1);
        chk("t2_first_data", {24'd0, prog_data}, 32'h10);
        chk("t2_ready_low_in_write", {31'd0, in_ready}, 32'd0);
        wait_idle_a("t2_finish", 60);
        chk("t2_done_edge", done_at_a, 33);
        chk("t2_idle_edge", edges_a, 34);
        chk("t2_select_back", {31'd0, select}, 32'd1);
        chk("t2_cpu_clr_back", {31'd0, cpu_clr}, 32'd0);
        chk("t2_addr_back", {28'd0, prog_addr}, 32'd0);
        chk("t2_first_addr", first_addr_a, 0);
        check_image_a("t2", 8'h10);

        // T3: random 0-5 cycle gaps on the stream
        for (int i = 0; i < 16; i++) ram_a[i] = 8'h00;
        start_a(8'h10, 1'b1);
        wait_idle_a("t3_finish", 400);
        check_image_a("t3", 8'h10);

        // T4: valid in IDLE ignored, START re-asserted mid-load ignored
        in_valid = 1'b1;
        nwe_a = 0;
        repeat (3) cycle();
        chk("t4_idle_no_we", nwe_a, 0);
        chk("t4_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        start_a(8'h40, 1'b0);
        repeat (5) cycle();
        start = 1'b1;
        repeat (3) cycle();
        start = 1'b0;
        wait_idle_a("t4_finish", 60);
        chk("t4_done_edge", done_at_a, 33);
        repeat (3) cycle();
        chk("t4_stays_idle", {31'd0, busy}, 32'd0);
        check_image_a("t4", 8'h40);

        // T5: 4 words with 3-clock write pulses
        start5 = 1'b1; valid5 = 1'b1; data5 = tb5[0]; idx_b = 0; edges_b = 0;
        cycle();
        start5 = 1'b0;
        n = 0;
        while (busy5 && n < 40) begin
            cycle();
            n++;
        end
        chk("t5_finish", {31'd0, busy5}, 32'd0);
        cycle();
        chk("t5_pulses", npulse_b, 4);
        chk("t5_pulse_len", badlen_b, 0);
        chk("t5_stable", unst_b, 0);
        chk("t5_ready_during_we", viol_b, 0);
        chk("t5_done_edge", done_at_b, 17);
        chk("t5_done_pulses", ndone_b, 1);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_ram%0d", i), {24'd0, ram_b[i]}, {24'd0, tb5[i]});
        chk("t5_select_back", {31'd0, select5}, 32'd1);
        valid5 = 1'b0;

        // T1/T6: clr while writing address 7, then reload from address 0
        start_a(8'h60, 1'b0);
        n = 0;
        while (!(prog_we && prog_addr == 4'd7) && n < 40) begin
            cycle();
            n++;
        end
        chk("t6_reached_addr7", {31'd0, prog_we}, 32'd1);
        #2 clr = 1'b1;
        #1;
        check_reset("t1_async");
        chk("t6_partial_kept", {24'd0, ram_a[6]}, 32'h66);
        @(negedge clk) clr = 1'b0;
        @(posedge clk);
        #1;
        start_a(8'h80, 1'b0);
        wait_idle_a("t6_finish", 60);
        chk("t6_restart_addr", first_addr_a, 0);
        check_image_a("t6", 8'h80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
